// File: rtl/par_frame_chk.sv
// Serial parity-frame checker: DATA_W data bits (LSB first) then one parity bit.
// Define PAR_FRAME_CHK_ERR_CNT_EN to add the saturating err_cnt output.
module par_frame_chk #(
  parameter int DATA_W  = 3,
  parameter int ODD_PAR = 0
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_vld,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_vld,
  output logic              par_err,
  output logic              busy
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int   CW      = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD_PAR != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              frame_vld_q, frame_vld_d;
  logic              par_err_q, par_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= 1'b0;
      data_out_q  <= '0;
      frame_vld_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      frame_vld_q <= frame_vld_d;
      par_err_q   <= par_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    frame_vld_d = 1'b0;
    par_err_d   = par_err_q;
    if (sin_vld) begin
      // sof always restarts, silently dropping any frame in flight
      if (sof) begin
        shreg_d    = '0;
        shreg_d[0] = sin;
        acc_d      = sin;
        bit_cnt_d  = CW'(1);
        state_d    = (DATA_W == 1) ? S_PAR : S_DATA;
      end else begin
        case (state_q)
          S_DATA: begin
            for (int i = 1; i < DATA_W; i++)
              if (bit_cnt_q == CW'(i)) shreg_d[i] = sin;
            acc_d     = acc_q ^ sin;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(DATA_W - 1)) state_d = S_PAR;
          end
          S_PAR: begin
            frame_vld_d = 1'b1;
            data_out_d  = shreg_q;
            par_err_d   = ((acc_q ^ sin) != ODD_BIT);
            state_d     = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign frame_vld = frame_vld_q;
  assign par_err   = par_err_q;
  assign busy      = (state_q == S_DATA) || (state_q == S_PAR);

`ifdef PAR_FRAME_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // counts on the completing edge so err_cnt is current while frame_vld is high
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_vld_d && par_err_d && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_par_frame_chk.sv
// Bench for par_frame_chk: three instances (even/3-bit, odd/3-bit, even/1-bit) driven
// by one stream and checked every cycle against a frame-level reference model.
module tb_par_frame_chk;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sin = 1'b0, sin_vld = 1'b0, sof = 1'b0;

  logic [2:0] do0, do1;
  logic [0:0] do2;
  logic [2:0] fv, pe, bz;
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
  logic [7:0] ec0;
  logic [1:0] ec1, ec2;
`endif

  always #5 clk = ~clk;

  par_frame_chk #(.DATA_W(3), .ODD_PAR(0)) u_e3 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .data_out(do0), .frame_vld(fv[0]), .par_err(pe[0]), .busy(bz[0])
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    , .err_cnt(ec0)
`endif
  );

  par_frame_chk #(.DATA_W(3), .ODD_PAR(1)
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) u_o3 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .data_out(do1), .frame_vld(fv[1]), .par_err(pe[1]), .busy(bz[1])
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );

  par_frame_chk #(.DATA_W(1), .ODD_PAR(0)
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) u_e1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .data_out(do2), .frame_vld(fv[2]), .par_err(pe[2]), .busy(bz[2])
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    , .err_cnt(ec2)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count bits collected for the frame in flight (0 = none);
  // when DATA_W bits are held, the next non-sof bit is the parity bit.
  int          dw[3]   = '{3, 3, 1};
  logic        odd[3]  = '{1'b0, 1'b1, 1'b0};
  int          cmax[3] = '{255, 3, 3};
  int          mn[3]   = '{0, 0, 0};
  logic [15:0] mw[3]   = '{16'd0, 16'd0, 16'd0};
  logic [15:0] mdo[3]  = '{16'd0, 16'd0, 16'd0};
  logic        mfv[3]  = '{1'b0, 1'b0, 1'b0};
  logic        mpe[3]  = '{1'b0, 1'b0, 1'b0};
  int          mec[3]  = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mn[k] = 0; mw[k] = '0; mdo[k] = '0; mfv[k] = 1'b0; mpe[k] = 1'b0; mec[k] = 0;
      end else begin
        mfv[k] = 1'b0;
        if (sin_vld) begin
          if (sof) begin
            mn[k] = 1;
            mw[k] = 16'(sin);
          end else if (mn[k] == dw[k]) begin
            mfv[k] = 1'b1;
            mdo[k] = mw[k];
            mpe[k] = ((^mw[k]) ^ sin) != odd[k];
            if (mpe[k] && mec[k] < cmax[k]) mec[k]++;
            mn[k] = 0;
          end else if (mn[k] > 0) begin
            mw[k][mn[k]] = sin;
            mn[k]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("e3_vld",  32'(fv[0]), 32'(mfv[0]));
      chk("e3_data", 32'(do0),   32'(mdo[0][2:0]));
      chk("e3_err",  32'(pe[0]), 32'(mpe[0]));
      chk("e3_busy", 32'(bz[0]), 32'(mn[0] > 0));
      chk("o3_vld",  32'(fv[1]), 32'(mfv[1]));
      chk("o3_data", 32'(do1),   32'(mdo[1][2:0]));
      chk("o3_err",  32'(pe[1]), 32'(mpe[1]));
      chk("o3_busy", 32'(bz[1]), 32'(mn[1] > 0));
      chk("e1_vld",  32'(fv[2]), 32'(mfv[2]));
      chk("e1_data", 32'(do2),   32'(mdo[2][0]));
      chk("e1_err",  32'(pe[2]), 32'(mpe[2]));
      chk("e1_busy", 32'(bz[2]), 32'(mn[2] > 0));
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
      chk("e3_cnt", 32'(ec0), 32'(mec[0]));
      chk("o3_cnt", 32'(ec1), 32'(mec[1]));
      chk("e1_cnt", 32'(ec2), 32'(mec[2]));
`endif
    end
  end

  int nvld0 = 0;
  always @(posedge clk) if (fv[0] === 1'b1) nvld0++;

  task automatic send(input logic v, input logic s, input logic f);
    @(negedge clk);
    sin_vld = v; sin = s; sof = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0);
  endtask

  int n_before;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(do0), 32'd0);
    chk("rst_vld",  32'(fv[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    run = 1'b1;
    idle(2);

    // 1,0,1 / p=0 even: clean; odd instance flags it
    send(1, 1, 1); send(1, 0, 0); send(1, 1, 0); send(1, 0, 0);
    idle(1);
    chk("t1_vld",  32'(fv[0]), 32'd1);
    chk("t1_data", 32'(do0),   32'b101);
    chk("t1_err",  32'(pe[0]), 32'd0);
    chk("t1_busy", 32'(bz[0]), 32'd0);
    chk("t1_odd",  32'(pe[1]), 32'd1);
    idle(1);

    send(1, 1, 1); send(1, 0, 0); send(1, 1, 0); send(1, 1, 0);
    idle(1);
    chk("t2_err", 32'(pe[0]), 32'd1);
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
    chk("t2_cnt", 32'(ec0), 32'd1);
`endif
    idle(1);

    // 0,1,1 / p=0 with two idle cycles between bits; busy must hold
    send(1, 0, 1); idle(2); chk("t3_gap0", 32'(bz[0]), 32'd1);
    send(1, 1, 0); idle(2); chk("t3_gap1", 32'(bz[0]), 32'd1);
    send(1, 1, 0); idle(2); chk("t3_gap2", 32'(bz[0]), 32'd1);
    send(1, 0, 0); idle(1);
    chk("t3_vld",  32'(fv[0]), 32'd1);
    chk("t3_data", 32'(do0),   32'b110);
    chk("t3_err",  32'(pe[0]), 32'd0);
    idle(1);

    // abort after two bits, then 1,1,1/p=1, then a frame whose sof rides on frame_vld
    n_before = nvld0;
    send(1, 1, 1); send(1, 0, 0);
    send(1, 1, 1); send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
    send(1, 0, 1);
    chk("t4_vld",  32'(fv[0]), 32'd1);
    chk("t4_data", 32'(do0),   32'b111);
    chk("t4_err",  32'(pe[0]), 32'd0);
    send(1, 0, 0); send(1, 1, 0); send(1, 1, 0);
    idle(1);
    chk("t4_vld2",  32'(fv[0]), 32'd1);
    chk("t4_data2", 32'(do0),   32'b100);
    chk("t4_err2",  32'(pe[0]), 32'd0);
    idle(2);
    chk("t4_pulses", 32'(nvld0 - n_before), 32'd2);

    // reset mid-frame
    send(1, 1, 1); send(1, 1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t5_data", 32'(do0),   32'd0);
    chk("t5_vld",  32'(fv[0]), 32'd0);
    chk("t5_err",  32'(pe[0]), 32'd0);
    chk("t5_busy", 32'(bz[0]), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    send(1, 1, 0);
    idle(1);
    chk("t5_ign", 32'(bz[0]), 32'd0);
    send(1, 1, 1); send(1, 1, 0); send(1, 0, 0); send(1, 0, 0);
    idle(1);
    chk("t5_vld2",  32'(fv[0]), 32'd1);
    chk("t5_data2", 32'(do0),   32'b011);
    chk("t5_err2",  32'(pe[0]), 32'd0);

    // odd parity, five 0,0,0/p=0 frames: counter saturates at 3
    for (int f = 0; f < 5; f++) begin
      send(1, 0, 1); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
      idle(1);
      chk("t6_err", 32'(pe[1]), 32'd1);
`ifdef PAR_FRAME_CHK_ERR_CNT_EN
      chk("t6_cnt", 32'(ec1), 32'((f < 3) ? f + 1 : 3));
`endif
    end

    // random traffic: model comparison runs every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 7)
        send(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      else
        send(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(3);
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/par_frame_chk.md
Name: par_frame_chk

Overview:
- Serial parity-frame checker; sits directly downstream of the 3-input parity generator.
- Receives a serial frame: DATA_W data bits (LSB first) followed by the generator's parity bit.
- Reassembles the data word, checks parity, and reports each completed frame with a one-cycle valid pulse.
- Default DATA_W=3 matches the generator's x/y/z word.

Parameters:
- DATA_W, 3: data bits per frame, range 1..16.
- ODD_PAR, 0: 0 = even parity (XOR of data and parity must be 0); 1 = odd parity (XOR must be 1).
- CNT_W, 8: width of the parity error counter (optional feature only).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial bit.
- sin_vld  in  1  sin is sampled only in cycles where sin_vld=1.
- sof  in  1  start of frame; qualifies a valid bit as data bit 0. Ignored when sin_vld=0.
- data_out  out  DATA_W  last completed frame's data word.
- frame_vld  out  1  one-cycle pulse per completed frame.
- par_err  out  1  parity result of the last completed frame (1 = mismatch).
- busy  out  1  high while in DATA or PAR state.
- err_cnt  out  CNT_W  saturating parity error count (ERR_CNT_EN only).

Behaviour:
- Reset (async assert, sync release): state=IDLE; data_out=0, frame_vld=0, par_err=0, busy=0, err_cnt=0; shift register, bit counter and parity accumulator cleared.
- An accepted bit is sin_vld=1 at a rising edge. With sin_vld=0 all state is held; there is no timeout.
- FSM states:
  - IDLE: accepted bit with sof=1 -> load bit 0, acc=sin, bit_cnt=1. Go to PAR if DATA_W==1, else DATA. Accepted bits with sof=0 are discarded.
  - DATA: accepted bit with sof=0 -> store at position bit_cnt, acc^=sin, bit_cnt++. After bit DATA_W-1 is stored, go to PAR.
  - PAR: accepted bit with sof=0 is the parity bit p. Compute err = ((acc^p) != ODD_PAR), register outputs, go to IDLE.
- sof=1 on an accepted bit in DATA or PAR: the current frame is aborted silently (no frame_vld, no error count). The bit becomes bit 0 of a new frame, exactly as from IDLE.
- Output timing: frame_vld=1 in the cycle after the parity bit's sampling edge. data_out and par_err update at that same edge and hold until the next completed frame.
- A new frame's sof bit is accepted in the cycle frame_vld is high, giving back-to-back frames with zero gap.
- busy=1 exactly while state is DATA or PAR.
- Reset asserted mid-frame: immediate return to IDLE; the partial frame is lost with no frame_vld.

Optional Feature:
- PAR_FRAME_CHK_ERR_CNT_EN
- Defined: err_cnt increments by 1 on every frame_vld with par_err=1. It saturates at 2^CNT_W-1 and is cleared only by rst_n.
- Undefined: the err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Even parity, DATA_W=3: bits 1,0,1 (sof on first) then p=0 -> one cycle later frame_vld=1, data_out=3'b101, par_err=0, busy=0.
- Same data with p=1 -> par_err=1; with the macro defined, err_cnt=1.
- Frame 0,1,1 / p=0 with sin_vld low for 2 cycles between every bit -> data_out=3'b110, par_err=0; busy stays 1 throughout the gaps.
- sof re-asserted after 2 data bits, then new frame 1,1,1 / p=1 -> exactly one frame_vld with data_out=3'b111, par_err=0. A second back-to-back frame whose sof coincides with frame_vld also completes.
- rst_n pulsed low after 2 data bits -> all outputs 0 immediately. A following non-sof bit is ignored; a subsequent full frame decodes correctly.
- ODD_PAR=1, CNT_W=2, macro defined: 5 frames of 0,0,0 / p=0 -> par_err=1 each time; err_cnt reads 1,2,3,3,3.
